// File: rtl/wb_regfile_pipe.sv
// Y86-64 writeback stage and register file: two commit ports (E, M),
// two decode read ports with optional same-cycle bypass, sticky status,
// halt flag and a saturating retired-instruction counter.
module wb_regfile_pipe #(
    parameter int unsigned     XLEN    = 64,
    parameter int unsigned     NREG    = 15,
    parameter logic [3:0]      RNONE   = 4'hF,
    parameter int unsigned     SP_IDX  = 4,
    parameter logic [XLEN-1:0] SP_INIT = '0,
    parameter bit              BYPASS  = 1'b1,
    parameter int unsigned     CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            W_stall,
    input  logic [1:0]      W_stat,
    input  logic [3:0]      W_icode,
    input  logic            W_cnd,
    input  logic [3:0]      W_dstE,
    input  logic [XLEN-1:0] W_valE,
    input  logic [3:0]      W_dstM,
    input  logic [XLEN-1:0] W_valM,
    input  logic [3:0]      d_srcA,
    input  logic [3:0]      d_srcB,
    output logic [XLEN-1:0] d_rvalA,
    output logic [XLEN-1:0] d_rvalB,
    output logic [1:0]      stat,
    output logic            halted,
    output logic [CNTW-1:0] retired
);
    localparam logic [1:0] STAT_AOK   = 2'd0;
    localparam logic [3:0] ICODE_CMOV = 4'h2;

    logic [XLEN-1:0] regs [NREG];
    logic            commit;
    logic            we_e;
    logic            we_m;
    logic            retire;

    // Commit qualification and per-port write enables
    always_comb begin
        commit = !W_stall && !halted && (W_stat == STAT_AOK);
        we_e   = commit && (W_dstE != RNONE) && (32'(W_dstE) < NREG)
                 && !((W_icode == ICODE_CMOV) && !W_cnd);
        we_m   = commit && (W_dstM != RNONE) && (32'(W_dstM) < NREG);
        retire = commit && (W_icode >= ICODE_CMOV);
    end

    // Array lookup with M-over-E bypass; invalid IDs read as zero
    function automatic logic [XLEN-1:0] read_port(input logic [3:0] id);
        logic [XLEN-1:0] v;
        v = '0;
        if ((id != RNONE) && (32'(id) < NREG)) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (id == 4'(i)) v = regs[i];
            end
            if (BYPASS && we_e && (id == W_dstE)) v = W_valE;
            if (BYPASS && we_m && (id == W_dstM)) v = W_valM;
        end
        return v;
    endfunction

    // Decode read ports
    always_comb begin
        d_rvalA = read_port(d_srcA);
        d_rvalB = read_port(d_srcB);
    end

    // Register array; M port wins when both ports hit the same ID
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (we_m && (W_dstM == 4'(i))) begin
                    regs[i] <= W_valM;
                end else if (we_e && (W_dstE == 4'(i))) begin
                    regs[i] <= W_valE;
                end
            end
        end
    end

    // Sticky status and halt flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat   <= STAT_AOK;
            halted <= 1'b0;
        end else if (!W_stall && !halted) begin
            stat <= W_stat;
            if (W_stat != STAT_AOK) halted <= 1'b1;
        end
    end

    // Saturating retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (retire && (retired != {CNTW{1'b1}})) begin
            retired <= retired + CNTW'(1);
        end
    end

endmodule
